// File: rtl/noise_rom_sched.sv
// Noise ROM scheduler: warm-up gate, two-channel round-robin grant of the shared
// sin/log ROM pair, and a fixed-latency response pipeline back to the requester.
module noise_rom_sched #(
  parameter int ROM_LAT = 2,
  parameter int WARMUP  = 32,
  parameter int DW      = 16
) (
  input  logic          clk100,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    req,
  input  logic [10:0]   rand_sin_addr,
  input  logic [9:0]    rand_log_addr,
  output logic [1:0]    gnt,
  output logic          rom_en,
  output logic [10:0]   sin_rom_addr,
  output logic [9:0]    log_rom_addr,
  input  logic [DW-1:0] sin_rom_data,
  input  logic [DW-1:0] log_rom_data,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_sin,
  output logic [DW-1:0] rsp_log,
  output logic          ready,
  output logic [15:0]   issue_cnt
);

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [7:0]      wu_cnt_r, wu_cnt_s;
  logic            ready_r;
  logic [1:0]      elig_s;
  logic [1:0]      gnt_s;
  logic            grant_s;
  logic [1:0]      gnt_r;
  logic            rom_en_r;
  logic            ptr_r;
  logic [10:0]     sin_addr_r;
  logic [9:0]      log_addr_r;
  logic [15:0]     issue_cnt_r;
  logic [ROM_LAT-1:0] vld_pipe_r;
  logic [ROM_LAT-1:0] id_pipe_r;
  logic [1:0]      rsp_valid_r;
  logic [DW-1:0]   rsp_sin_r;
  logic [DW-1:0]   rsp_log_r;

  // Warm-up sequencer next-state logic
  always_comb begin
    state_s  = state_r;
    wu_cnt_s = wu_cnt_r;
    case (state_r)
      ST_WARMUP: begin
        if (wu_cnt_r == 8'(WARMUP - 1)) begin
          state_s  = ST_RUN;
          wu_cnt_s = 8'd0;
        end else begin
          wu_cnt_s = wu_cnt_r + 8'd1;
        end
      end
      ST_RUN: begin
        state_s = ST_RUN;
      end
      default: begin
        state_s  = ST_WARMUP;
        wu_cnt_s = 8'd0;
      end
    endcase
  end

  // Round-robin arbiter; a channel whose grant is currently showing is masked out
  always_comb begin
    elig_s = req & ~gnt_r;
    gnt_s  = 2'b00;
    if ((state_r == ST_RUN) && en) begin
      case (elig_s)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = ptr_r ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
    grant_s = |gnt_s;
  end

  // State, grant, ROM address and issue counter registers
  always_ff @(posedge clk100) begin
    if (!rst) begin
      state_r     <= ST_WARMUP;
      wu_cnt_r    <= 8'd0;
      ready_r     <= 1'b0;
      gnt_r       <= 2'b00;
      rom_en_r    <= 1'b0;
      ptr_r       <= 1'b0;
      sin_addr_r  <= 11'd0;
      log_addr_r  <= 10'd0;
      issue_cnt_r <= 16'd0;
    end else begin
      state_r  <= state_s;
      wu_cnt_r <= wu_cnt_s;
      ready_r  <= (state_s == ST_RUN);
      gnt_r    <= gnt_s;
      rom_en_r <= grant_s;
      if (grant_s) begin
        sin_addr_r  <= rand_sin_addr;
        log_addr_r  <= rand_log_addr;
        ptr_r       <= gnt_s[0];
        issue_cnt_r <= issue_cnt_r + 16'd1;
      end
    end
  end

  // In-flight read tracking and response capture, fed by the ROM strobe
  always_ff @(posedge clk100) begin
    if (!rst) begin
      vld_pipe_r  <= '0;
      id_pipe_r   <= '0;
      rsp_valid_r <= 2'b00;
      rsp_sin_r   <= '0;
      rsp_log_r   <= '0;
    end else begin
      vld_pipe_r[0] <= rom_en_r;
      id_pipe_r[0]  <= gnt_r[1];
      for (int k = 1; k < ROM_LAT; k++) begin
        vld_pipe_r[k] <= vld_pipe_r[k-1];
        id_pipe_r[k]  <= id_pipe_r[k-1];
      end
      if (vld_pipe_r[ROM_LAT-1]) begin
        rsp_sin_r   <= sin_rom_data;
        rsp_log_r   <= log_rom_data;
        rsp_valid_r <= id_pipe_r[ROM_LAT-1] ? 2'b10 : 2'b01;
      end else begin
        rsp_valid_r <= 2'b00;
      end
    end
  end

  assign gnt          = gnt_r;
  assign rom_en       = rom_en_r;
  assign sin_rom_addr = sin_addr_r;
  assign log_rom_addr = log_addr_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_sin      = rsp_sin_r;
  assign rsp_log      = rsp_log_r;
  assign ready        = ready_r;
  assign issue_cnt    = issue_cnt_r;

endmodule

// File: tb/tb_noise_rom_sched.sv
// Directed bench for noise_rom_sched with a two-stage ROM model (data = addr ^ const).
module tb_noise_rom_sched;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  req;
  logic [10:0] rand_sin_addr;
  logic [9:0]  rand_log_addr;
  logic [1:0]  gnt;
  logic        rom_en;
  logic [10:0] sin_rom_addr;
  logic [9:0]  log_rom_addr;
  logic [15:0] sin_rom_data;
  logic [15:0] log_rom_data;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_sin;
  logic [15:0] rsp_log;
  logic        ready;
  logic [15:0] issue_cnt;

  logic [15:0] sin_s1, sin_s2, log_s1, log_s2;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  req;
    logic        en;
    logic [10:0] sin;
    logic [9:0]  log_a;
    logic [1:0]  gnt;
    logic        rom_en;
    logic [10:0] sin_addr;
    logic [9:0]  log_addr;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_sin;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [7];

  noise_rom_sched dut (
    .clk100        (clk100),
    .rst           (rst),
    .en            (en),
    .req           (req),
    .rand_sin_addr (rand_sin_addr),
    .rand_log_addr (rand_log_addr),
    .gnt           (gnt),
    .rom_en        (rom_en),
    .sin_rom_addr  (sin_rom_addr),
    .log_rom_addr  (log_rom_addr),
    .sin_rom_data  (sin_rom_data),
    .log_rom_data  (log_rom_data),
    .rsp_valid     (rsp_valid),
    .rsp_sin       (rsp_sin),
    .rsp_log       (rsp_log),
    .ready         (ready),
    .issue_cnt     (issue_cnt)
  );

  always #5 clk100 = ~clk100;

  // ROM model: address sampled on one edge, data valid two edges later
  always @(posedge clk100) begin
    sin_s1 <= {5'd0, sin_rom_addr} ^ 16'h1234;
    sin_s2 <= sin_s1;
    log_s1 <= {6'd0, log_rom_addr} ^ 16'h0F0F;
    log_s2 <= log_s1;
  end
  assign sin_rom_data = sin_s2;
  assign log_rom_data = log_s2;

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int grants;
    bit done;

    tbl[0] = '{2'b11, 1'b1, 11'h5A3, 10'h155, 2'b01, 1'b1, 11'h5A3, 10'h155, 2'b00, 16'h0000, 16'd1};
    tbl[1] = '{2'b11, 1'b1, 11'h111, 10'h0AA, 2'b10, 1'b1, 11'h111, 10'h0AA, 2'b00, 16'h0000, 16'd2};
    tbl[2] = '{2'b11, 1'b1, 11'h222, 10'h2CC, 2'b01, 1'b1, 11'h222, 10'h2CC, 2'b00, 16'h0000, 16'd3};
    tbl[3] = '{2'b00, 1'b1, 11'h333, 10'h333, 2'b00, 1'b0, 11'h222, 10'h2CC, 2'b01, 16'h1797, 16'd3};
    tbl[4] = '{2'b00, 1'b1, 11'h333, 10'h333, 2'b00, 1'b0, 11'h222, 10'h2CC, 2'b10, 16'h1325, 16'd3};
    tbl[5] = '{2'b00, 1'b1, 11'h333, 10'h333, 2'b00, 1'b0, 11'h222, 10'h2CC, 2'b01, 16'h1016, 16'd3};
    tbl[6] = '{2'b00, 1'b1, 11'h333, 10'h333, 2'b00, 1'b0, 11'h222, 10'h2CC, 2'b00, 16'h1016, 16'd3};

    rst = 1'b0; en = 1'b0; req = 2'b00; rand_sin_addr = 11'd0; rand_log_addr = 10'd0;
    for (int i = 0; i < 3; i++) step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rom_en", 32'(rom_en), 32'h0);
    check("rst_sin_addr", 32'(sin_rom_addr), 32'h0);
    check("rst_log_addr", 32'(log_rom_addr), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_sin", 32'(rsp_sin), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'h0);

    // warm-up: requests pending, nothing granted for 32 edges
    rst = 1'b1; req = 2'b11; en = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      check("warmup_gnt", 32'(gnt), 32'h0);
      check("warmup_ready", 32'(ready), (i == 32) ? 32'h1 : 32'h0);
    end

    // round-robin, address capture and response latency
    for (int r = 0; r < 7; r++) begin
      req = tbl[r].req; en = tbl[r].en;
      rand_sin_addr = tbl[r].sin; rand_log_addr = tbl[r].log_a;
      step();
      check($sformatf("tbl%0d_gnt", r), 32'(gnt), 32'(tbl[r].gnt));
      check($sformatf("tbl%0d_rom_en", r), 32'(rom_en), 32'(tbl[r].rom_en));
      check($sformatf("tbl%0d_sin_addr", r), 32'(sin_rom_addr), 32'(tbl[r].sin_addr));
      check($sformatf("tbl%0d_log_addr", r), 32'(log_rom_addr), 32'(tbl[r].log_addr));
      check($sformatf("tbl%0d_rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rsp_valid));
      check($sformatf("tbl%0d_rsp_sin", r), 32'(rsp_sin), 32'(tbl[r].rsp_sin));
      check($sformatf("tbl%0d_issue_cnt", r), 32'(issue_cnt), 32'(tbl[r].cnt));
    end

    // lone channel 0 with pointer at 1, held past its grant: no double grant
    req = 2'b01;
    step(); check("solo0_gnt", 32'(gnt), 32'h1);
    step(); check("solo0_hold", 32'(gnt), 32'h0);
    req = 2'b00;
    step(); check("solo0_drop", 32'(gnt), 32'h0);

    // lone channel 1 held: granted every eligible edge, including with pointer at 0
    req = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      check("solo1_gnt", 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h0);
    end
    req = 2'b00;
    for (int i = 0; i < 5; i++) step();
    check("solo_issue_cnt", 32'(issue_cnt), 32'd7);

    // en drop with two reads in flight
    req = 2'b11; rand_sin_addr = 11'h0A0; rand_log_addr = 10'h2A0;
    step(); check("endrop_g0", 32'(gnt), 32'h1);
    rand_sin_addr = 11'h0B0; rand_log_addr = 10'h3C3;
    step(); check("endrop_g1", 32'(gnt), 32'h2);
    en = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      step();
      check("endrop_gnt", 32'(gnt), 32'h0);
      check("endrop_rsp_valid", 32'(rsp_valid), (k == 3) ? 32'h1 : ((k == 4) ? 32'h2 : 32'h0));
      if (k == 3) check("endrop_rsp_sin0", 32'(rsp_sin), 32'h1294);
      if (k == 4) begin
        check("endrop_rsp_sin1", 32'(rsp_sin), 32'h1284);
        check("endrop_rsp_log1", 32'(rsp_log), 32'h0CCC);
      end
    end
    check("endrop_issue_cnt", 32'(issue_cnt), 32'd9);

    // reset one cycle after rom_en: the in-flight read must vanish
    en = 1'b1; req = 2'b01;
    step(); check("midrst_rom_en", 32'(rom_en), 32'h1);
    req = 2'b00; rst = 1'b0;
    step();
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_rom_en0", 32'(rom_en), 32'h0);
    check("midrst_sin_addr", 32'(sin_rom_addr), 32'h0);
    check("midrst_log_addr", 32'(log_rom_addr), 32'h0);
    check("midrst_rsp_sin", 32'(rsp_sin), 32'h0);
    check("midrst_rsp_log", 32'(rsp_log), 32'h0);
    check("midrst_ready", 32'(ready), 32'h0);
    check("midrst_issue_cnt", 32'(issue_cnt), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      step();
    end
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);

    // counter wrap after 65536 grants
    req = 2'b11;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (ready) done = 1'b1;
    end
    check("wrap_ready_seen", 32'(done), 32'h1);
    grants = 0;
    done = 1'b0;
    for (int i = 0; i < 70000 && !done; i++) begin
      step();
      if (gnt != 2'b00) begin
        grants++;
        if (grants == 65535) check("wrap_cnt_ffff", 32'(issue_cnt), 32'hFFFF);
        if (grants == 65536) begin
          check("wrap_cnt_zero", 32'(issue_cnt), 32'h0);
          done = 1'b1;
        end
      end
    end
    check("wrap_reached", 32'(done), 32'h1);
    req = 2'b00;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/noise_rom_sched.md
NOISE_ROM_SCHED -- requirements
Module: noise_rom_sched

Interface
REQ-001 SHALL have parameter ROM_LAT, default 2, meaning ROM read latency in cycles from rom_en to valid data (legal range 1..4).
REQ-002 SHALL have parameter WARMUP, default 32, meaning cycles after reset release before the first grant (legal range 1..255).
REQ-003 SHALL have parameter DW, default 16, meaning ROM data width.
REQ-004 SHALL have port clk100, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port en, input, 1 bit: when low, no new grants are issued.
REQ-007 SHALL have port req, input, 2 bits: requests from noise channels 0 and 1; each is level, held until granted.
REQ-008 SHALL have port rand_sin_addr, input, 11 bits: random sin ROM address from the random generator.
REQ-009 SHALL have port rand_log_addr, input, 10 bits: random log ROM address from the random generator.
REQ-010 SHALL have port gnt, output, 2 bits: one-cycle grant pulse, at most one bit set.
REQ-011 SHALL have port rom_en, output, 1 bit: read strobe to both ROMs.
REQ-012 SHALL have port sin_rom_addr, output, 11 bits: registered sin ROM address.
REQ-013 SHALL have port log_rom_addr, output, 10 bits: registered log ROM address.
REQ-014 SHALL have port sin_rom_data, input, DW bits: sin ROM output.
REQ-015 SHALL have port log_rom_data, input, DW bits: log ROM output.
REQ-016 SHALL have port rsp_valid, output, 2 bits: one-cycle response strobe per channel.
REQ-017 SHALL have port rsp_sin, output, DW bits: captured sin ROM data.
REQ-018 SHALL have port rsp_log, output, DW bits: captured log ROM data.
REQ-019 SHALL have port ready, output, 1 bit: high once warm-up completes.
REQ-020 SHALL have port issue_cnt, output, 16 bits: count of grants issued.

Function
REQ-021 SHALL implement states WARMUP and RUN; reset enters WARMUP; after exactly WARMUP cycles in WARMUP the block moves to RUN and sets ready=1; RUN persists until reset.
REQ-022 SHALL issue no grant in WARMUP regardless of req and en.
REQ-023 SHALL, in RUN with en=1, at each rising edge where req!=0, register one grant; gnt, rom_en=1, sin_rom_addr=rand_sin_addr and log_rom_addr=rand_log_addr (values sampled at that edge) all become visible in the following cycle.
REQ-024 SHALL arbitrate round-robin: a 1-bit pointer names the priority channel; after granting channel i the pointer becomes 1-i; with only one requester, that requester wins regardless of the pointer.
REQ-025 SHALL NOT grant a channel in the cycle its gnt is high, so a requester that drops req on seeing gnt is not double-granted; with both channels requesting continuously, grants alternate 0,1,0,1.
REQ-026 SHALL hold rom_en=0 and both ROM addresses at their last value when no grant is issued.
REQ-027 SHALL track in-flight reads with a ROM_LAT-deep valid/id shift pipeline; ROM_LAT cycles after a rom_en cycle, it captures sin_rom_data and log_rom_data into rsp_sin and rsp_log and pulses rsp_valid[id] for one cycle the next cycle.
REQ-028 SHALL give a fixed end-to-end latency from the grant edge to rsp_valid of ROM_LAT+1 cycles; back-to-back grants yield back-to-back responses in grant order.
REQ-029 SHALL hold rsp_sin and rsp_log between responses.
REQ-030 SHALL complete in-flight reads normally when en falls; en=0 blocks only new grants.
REQ-031 SHALL increment issue_cnt by 1 per grant, wrapping from 0xFFFF to 0x0000.

Reset
REQ-032 SHALL, on rst=0 at a clock edge, set gnt=0, rom_en=0, sin_rom_addr=0, log_rom_addr=0, rsp_valid=0, rsp_sin=0, rsp_log=0, ready=0, issue_cnt=0, pointer to channel 0, the pipeline cleared and state WARMUP.
REQ-033 SHALL discard in-flight reads on reset asserted mid-operation; no rsp_valid may appear after reset from reads issued before it.

Verification
REQ-034 SHALL cover warm-up: release reset with req=2'b11 and en=1 -> no gnt for 32 cycles, ready rises at cycle 32, first gnt=2'b01.
REQ-035 SHALL cover round-robin and latency: both req held, rand_sin_addr=0x5A3 at the grant edge -> gnt sequence 01,10,01; sin_rom_addr=0x5A3 with rom_en; rsp_valid[0] 3 cycles after the grant edge (ROM_LAT=2).
REQ-036 SHALL cover a single requester: req=2'b10 held with pointer at 0 -> channel 1 is granted on consecutive eligible edges without starvation.
REQ-037 SHALL cover en drop: drop en with 2 reads in flight -> both rsp_valid pulses occur and no further gnt.
REQ-038 SHALL cover reset mid-flight: assert rst=0 one cycle after rom_en -> no rsp_valid afterwards and all outputs 0.
REQ-039 SHALL cover counter wrap: 65536 grants -> issue_cnt returns to 0x0000.
